// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake, registered result and {Z,N,C,V} flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for op 12.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_INC = OPW'(2);
  localparam logic [OPW-1:0] OP_DEC = OPW'(3);
  localparam logic [OPW-1:0] OP_AND = OPW'(4);
  localparam logic [OPW-1:0] OP_OR  = OPW'(5);
  localparam logic [OPW-1:0] OP_NOT = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR = OPW'(7);
  localparam logic [OPW-1:0] OP_NEG = OPW'(8);
  localparam logic [OPW-1:0] OP_SHL = OPW'(9);
  localparam logic [OPW-1:0] OP_SHR = OPW'(10);
  localparam logic [OPW-1:0] OP_SAR = OPW'(11);
`ifdef ALU_MUL_EN
  localparam logic [OPW-1:0] OP_MUL = OPW'(12);
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] add_a, add_b;
  logic             add_sub, add_v;
  logic [WIDTH:0]   add_w, shl_w, shr_w, sar_w;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d, mul_step;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_res;

  // Shift-add: accumulate into the upper half, shift the multiplier out the bottom.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_res  = mul_step[WIDTH-1:0];
`endif

  // Shared adder/subtractor; the extra top bit is carry-out or borrow.
  always_comb begin : add_sel
    add_a   = i1;
    add_b   = i2;
    add_sub = 1'b0;
    case (op)
      OP_SUB: add_sub = 1'b1;
      OP_INC: add_b = WIDTH'(1);
      OP_DEC: begin
        add_b   = WIDTH'(1);
        add_sub = 1'b1;
      end
      OP_NEG: begin
        add_a   = '0;
        add_b   = i1;
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_w = add_sub ? ({1'b0, add_a} - {1'b0, add_b}) : ({1'b0, add_a} + {1'b0, add_b});
  assign add_v = (add_a[WIDTH-1] == (add_b[WIDTH-1] ^ add_sub)) &&
                 (add_w[WIDTH-1] != add_a[WIDTH-1]);

  // Widened shifters expose the last bit shifted out.
  assign shamt = i2[SW-1:0];
  assign shl_w = {1'b0, i1} << shamt;
  assign shr_w = {i1, 1'b0} >> shamt;
  assign sar_w = $signed({i1, 1'b0}) >>> shamt;

  always_comb begin : alu_op
    alu_res = i1;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = add_v;
      end
      OP_AND: alu_res = i1 & i2;
      OP_OR:  alu_res = i1 | i2;
      OP_NOT: alu_res = ~i1;
      OP_XOR: alu_res = i1 ^ i2;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_SAR: begin
        alu_res = sar_w[WIDTH:1];
        alu_c   = sar_w[0];
      end
      default: ;
    endcase
  end

  assign alu_flags = {alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v};
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);

  always_comb begin : fsm_next
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
`ifdef ALU_MUL_EN
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
`endif
    if (clr) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if ((state_q == DONE) && out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
          if (in_valid && in_ready) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = alu_res;
            flags_d     = alu_flags;
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
              state_d     = BUSY;
              out_valid_d = 1'b0;
              result_d    = result_q;
              flags_d     = flags_q;
              prod_d      = {{WIDTH{1'b0}}, i2};
              mcand_d     = i1;
              cnt_d       = '0;
            end
`endif
          end
        end
`ifdef ALU_MUL_EN
        BUSY: begin
          prod_d = mul_step;
          cnt_d  = cnt_q + SW'(1);
          if (cnt_q == SW'(WIDTH - 1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = mul_res;
            flags_d     = {mul_res == '0, mul_res[WIDTH-1], |mul_step[2*WIDTH-1:WIDTH], 1'b0};
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
`ifdef ALU_MUL_EN
      prod_q      <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
`ifdef ALU_MUL_EN
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed corner cases plus random ops vs. an arithmetic model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op, flags;
  logic [31:0] i1, i2, result;

  int total = 0;
  int bad   = 0;

`ifdef ALU_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 1;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  alu_mc #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .i1(i1), .i2(i2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  // Reference: results from 64-bit integer arithmetic, flags from their definitions.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f);
    longint unsigned ua, ub, full;
    longint sa, sb, ss;
    int s;
    logic c, v;
    ua = 64'(a); ub = 64'(b);
    sa = $signed(a); sb = $signed(b);
    s  = int'(b[4:0]);
    c = 1'b0; v = 1'b0; r = a;
    case (o)
      4'd0: begin full = ua + ub; r = full[31:0]; c = full[32]; ss = sa + sb; v = ss > SMAX || ss < SMIN; end
      4'd1: begin r = a - b; c = ua < ub; ss = sa - sb; v = ss > SMAX || ss < SMIN; end
      4'd2: begin r = a + 32'd1; c = (a == 32'hFFFF_FFFF); v = (a == 32'h7FFF_FFFF); end
      4'd3: begin r = a - 32'd1; c = (a == 32'd0); v = (a == 32'h8000_0000); end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = ~a;
      4'd7: r = a ^ b;
      4'd8: begin r = 32'd0 - a; c = (a != 0); ss = -sa; v = ss > SMAX; end
      4'd9: begin r = a << s; c = (s != 0) ? a[32 - s] : 1'b0; end
      4'd10: begin r = a >> s; c = (s != 0) ? a[s - 1] : 1'b0; end
      4'd11: begin r = 32'($signed(a) >>> s); c = (s != 0) ? a[s - 1] : 1'b0; end
`ifdef ALU_MUL_EN
      4'd12: begin full = ua * ub; r = full[31:0]; c = (full[63:32] != 0); end
`endif
      default: r = a;
    endcase
    f = {r == 32'd0, r[31], c, v};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready low, check latency and outputs, then consume it.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input string nm);
    logic [31:0] er;
    logic [3:0]  ef;
    int lat, exp_lat;
    model(o, a, b, er, ef);
    exp_lat = (o == 4'd12) ? MUL_LAT : 1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready got=%b want=1", nm, in_ready); end
    op = o; i1 = a; i2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; op = 4'($urandom); i1 = $urandom; i2 = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin tick(); lat++; end
    total++;
    if (lat != exp_lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", nm, lat, exp_lat); end
    total++;
    if (result !== er || flags !== ef) begin
      bad++;
      $display("FAIL %s op=%0d a=%h b=%h result got=%h want=%h flags got=%b want=%b",
               nm, o, a, b, result, er, flags, ef);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; i1 = '0; i2 = '0;
    #12;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0 || flags !== 4'd0) begin
      bad++; $display("FAIL reset out_valid=%b result=%h flags=%b want 0/0/0", out_valid, result, flags);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, "add_wrap");
    total++;
    if (result !== 32'd0 || flags !== 4'b1010) begin
      bad++; $display("FAIL add_wrap_const result=%h flags=%b want 00000000/1010", result, flags);
    end
    run_op(4'd1, 32'h8000_0000, 32'd1, "sub_ovf");
    total++;
    if (result !== 32'h7FFF_FFFF || flags !== 4'b0001) begin
      bad++; $display("FAIL sub_ovf_const result=%h flags=%b want 7fffffff/0001", result, flags);
    end
    run_op(4'd11, 32'h8000_0000, 32'h21, "sar_mask");
    total++;
    if (result !== 32'hC000_0000 || flags !== 4'b0100) begin
      bad++; $display("FAIL sar_mask_const result=%h flags=%b want c0000000/0100", result, flags);
    end
    run_op(4'd8, 32'h8000_0000, 32'd0, "neg_min");
    run_op(4'd9, 32'h8000_0001, 32'd1, "shl_carry");
    run_op(4'd10, 32'h0000_0003, 32'd0, "shr_zero");
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) run_op(4'($urandom_range(0, 15)), pick(), pick(), "random");
  endtask

  task automatic test_mul_backpressure();
    logic [31:0] er;
    logic [3:0]  ef;
    int lat;
    model(4'd12, 32'h0001_0000, 32'h0001_0000, er, ef);
    out_ready = 1'b0;
    op = 4'd12; i1 = 32'h0001_0000; i2 = 32'h0001_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin tick(); lat++; end
    total++;
    if (lat != MUL_LAT) begin bad++; $display("FAIL mul_latency got=%0d want=%0d", lat, MUL_LAT); end
    in_valid = 1'b1; op = 4'd0; i1 = 32'd5; i2 = 32'd6;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || flags !== ef) begin
        bad++;
        $display("FAIL mul_hold cyc=%0d ov=%b ir=%b result got=%h want=%h flags got=%b want=%b",
                 k, out_valid, in_ready, result, er, flags, ef);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mul_consume out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  o;
    logic [31:0] a, b, er;
    logic [3:0]  ef;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      o = 4'($urandom_range(0, 15));
      if (o == 4'd12) o = 4'd13;
      a = pick(); b = pick();
      model(o, a, b, er, ef);
      op = o; i1 = a; i2 = b; in_valid = 1'b1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b want=1", k, in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || result !== er || flags !== ef) begin
        bad++;
        $display("FAIL b2b k=%0d ov=%b result got=%h want=%h flags got=%b want=%b",
                 k, out_valid, result, er, flags, ef);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_clr();
    int seen;
    out_ready = 1'b0;
    op = 4'd7; i1 = 32'h1234_5678; i2 = 32'hFF00_FF00; in_valid = 1'b1;
    tick();
    op = 4'd0; i1 = 32'd1; i2 = 32'd2; out_ready = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || result !== 32'hED34_A978 || flags !== 4'b0100) begin
      bad++; $display("FAIL clr out_valid=%b result=%h flags=%b want 0/ed34a978/0100", out_valid, result, flags);
    end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    total++;
    if (seen != 0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL clr_no_accept valid_cycles got=%0d want=0 in_ready=%b", seen, in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    out_ready = 1'b0;
    op = 4'd12; i1 = 32'hDEAD_BEEF; i2 = 32'h0000_0003; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0 || flags !== 4'd0) begin
      bad++; $display("FAIL reset_mid_mul out_valid=%b result=%h flags=%b want 0/0/0", out_valid, result, flags);
    end
    #2;
    rst_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_mid_mul_ready got=%b want=1", in_ready); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_abandon valid_cycles got=%0d want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mul_backpressure();
    test_back_to_back();
    test_clr();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the execute stage, replacing the single-cycle combinational ALU. Operands and opcode are accepted over a valid/ready handshake. The result is registered together with Z/N/C/V flags. Shift ops and an iterative multiplier are added, so results arrive with variable latency and are held until the consumer takes them.

## Interface
- `WIDTH`, 32: operand and result width. Must be a power of two, ≥ 8.
- `OPW`, 4: opcode width.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clr` input 1: synchronous abort. Drops any in-flight or held result.
- `in_valid` input 1: operands and opcode are valid this cycle.
- `in_ready` output 1: block can accept an operation this cycle.
- `op` input OPW: opcode.
- `i1`, `i2` input WIDTH each: operands.
- `out_valid` output 1: `result` and `flags` are valid.
- `out_ready` input 1: consumer takes the result this cycle.
- `result` output WIDTH: registered result.
- `flags` output 4: {Z, N, C, V}, registered.

## Operation
- Opcodes:
  - 0 ADD i1+i2
  - 1 SUB i1−i2
  - 2 INC i1+1
  - 3 DEC i1−1
  - 4 AND
  - 5 OR
  - 6 NOT ~i1
  - 7 XOR
  - 8 NEG −i1 (i.e. 0−i1)
  - 9 SHL, i1 << s
  - 10 SHR, logical
  - 11 SAR, arithmetic
  - 12 MUL, low WIDTH bits of unsigned i1×i2
  - 13–15 pass i1
- Shift amount s = i2[log2(WIDTH)−1:0]. Upper bits of i2 are ignored.
- Arithmetic is modulo 2^WIDTH.
- Flags:
  - Z = (result == 0).
  - N = result[WIDTH−1].
  - C:
    - ADD/INC: carry-out.
    - SUB/DEC/NEG: borrow, i.e. unsigned minuend < subtrahend (NEG: C = i1≠0).
    - Shifts: last bit shifted out (0 when s=0).
    - MUL: 1 if the high half of the product is non-zero.
    - All other ops: 0.
  - V: signed overflow for ADD/SUB/INC/DEC/NEG; 0 for all other ops.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: accept when in_valid. MUL goes to BUSY with the operands latched. Every other op computes and goes to DONE.
  - BUSY: one shift-add step per cycle. After WIDTH steps, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE, or accept a new op in the same cycle (see in_ready).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Operands are sampled only at accept. Later changes to i1/i2/op have no effect.

## Timing
- Reset (rst_n=0, asynchronous):
  - state IDLE
  - out_valid=0
  - result=0
  - flags=0
  - in_ready=1 once rst_n is high
- Non-MUL latency: accept in cycle t → out_valid in cycle t+1.
- MUL latency: accept in cycle t → out_valid in cycle t+WIDTH+1.
- Throughput for non-MUL ops with out_ready held high: one op per cycle (back-to-back accept in DONE).
- Backpressure: while out_valid && !out_ready, result and flags hold stable and in_ready=0.
- clr has priority over everything except rst_n. On clr:
  - next state IDLE
  - out_valid=0
  - result and flags keep their last value
  - an in_valid presented in the same cycle is not accepted
- A reset in the middle of a MUL abandons it. No output is produced for that op.

## Configuration
- `ALU_MUL_EN` defined:
  - MUL (op 12) is built as the iterative multiplier.
  - MUL uses BUSY with latency WIDTH+1.
- `ALU_MUL_EN` undefined:
  - No multiplier datapath or counter is built.
  - BUSY is unreachable.
  - op 12 behaves as pass i1 with 1-cycle latency and flags per the pass rule (C=V=0).

## Test plan
- Reset: assert rst_n=0 mid-MUL → out_valid=0, result=0, flags=0 immediately. After release, in_ready=1.
- WIDTH=32, ADD 0xFFFFFFFF + 1 → result 0, flags Z=1 N=0 C=1 V=0, one cycle after accept.
- SUB 0x80000000 − 1 → result 0x7FFFFFFF, V=1, C=0.
- SAR 0x80000000 by i2=0x21 (s=1) → result 0xC0000000, N=1, C=0.
- MUL 0x10000 × 0x10000, with ALU_MUL_EN:
  - out_valid exactly 33 cycles after accept, result 0, C=1.
  - With out_ready low for 5 cycles, result is held and in_ready=0 throughout.
- Back-to-back ADD stream with out_ready=1 → one result per cycle.
- clr asserted while DONE → out_valid drops next cycle and the new in_valid in the clr cycle is not accepted.
